// File: rtl/pay_ctrl.sv
// pay_ctrl: payment controller FSM for the card-payment front panel.
// Converts debounced card-slot and push-button levels into the
// state/cost/left/press/cancel_flag/err bus consumed by the display block,
// holds the card balance and debits it on a confirmed purchase.
//
// Ports:
//   clk_N        system clock, rising edge
//   rst          asynchronous active-high reset
//   card_in      card-present level
//   btn_ok       confirm button level
//   btn_cancel   cancel button level
//   btn_up       increase-cost button level
//   btn_down     decrease-cost button level
//   state        00 IDLE, 01 CARD, 10 INPUT, 11 DONE
//   cost         purchase amount being entered / charged
//   left         card balance
//   press        one-cycle confirm-accepted strobe
//   cancel_flag  one-cycle cancel strobe
//   err          insufficient-balance indicator
module pay_ctrl #(
  parameter logic [7:0]  INIT_LEFT   = 8'd132,
  parameter logic [7:0]  STEP        = 8'd1,
  parameter logic [15:0] DONE_CYCLES = 16'd100
) (
  input  logic       clk_N,
  input  logic       rst,
  input  logic       card_in,
  input  logic       btn_ok,
  input  logic       btn_cancel,
  input  logic       btn_up,
  input  logic       btn_down,
  output logic [1:0] state,
  output logic [7:0] cost,
  output logic [7:0] left,
  output logic       press,
  output logic       cancel_flag,
  output logic       err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_CARD  = 2'b01,
    S_INPUT = 2'b10,
    S_DONE  = 2'b11
  } state_t;

  state_t      state_q, state_n;
  logic [7:0]  cost_q, cost_n;
  logic [7:0]  left_q, left_n;
  logic        press_q, press_n;
  logic        cancel_q, cancel_n;
  logic        err_q, err_n;
  logic [15:0] timer_q, timer_n;

  logic ok_prev, cancel_prev, up_prev, down_prev;
  logic ok_edge, cancel_edge, up_edge, down_edge;
  logic ev_cancel, ev_ok, ev_up, ev_down;

  logic [8:0]  up_sum;
  logic [7:0]  cost_up, cost_down;
  logic [15:0] timer_last;

  assign ok_edge     = btn_ok     & ~ok_prev;
  assign cancel_edge = btn_cancel & ~cancel_prev;
  assign up_edge     = btn_up     & ~up_prev;
  assign down_edge   = btn_down   & ~down_prev;

  // Only the highest-priority edge of a cycle survives; card removal is
  // handled ahead of all of these in the next-state logic.
  assign ev_cancel = cancel_edge;
  assign ev_ok     = ok_edge   & ~cancel_edge;
  assign ev_up     = up_edge   & ~cancel_edge & ~ok_edge;
  assign ev_down   = down_edge & ~cancel_edge & ~ok_edge & ~up_edge;

  assign up_sum     = {1'b0, cost_q} + {1'b0, STEP};
  assign cost_up    = (up_sum > 9'd255) ? 8'hFF : up_sum[7:0];
  assign cost_down  = (cost_q < STEP) ? '0 : cost_q - STEP;
  assign timer_last = DONE_CYCLES - 16'd1;

  always_ff @(posedge clk_N or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cost_q      <= '0;
      left_q      <= INIT_LEFT;
      press_q     <= 1'b0;
      cancel_q    <= 1'b0;
      err_q       <= 1'b0;
      timer_q     <= '0;
      ok_prev     <= 1'b0;
      cancel_prev <= 1'b0;
      up_prev     <= 1'b0;
      down_prev   <= 1'b0;
    end else begin
      state_q     <= state_n;
      cost_q      <= cost_n;
      left_q      <= left_n;
      press_q     <= press_n;
      cancel_q    <= cancel_n;
      err_q       <= err_n;
      timer_q     <= timer_n;
      ok_prev     <= btn_ok;
      cancel_prev <= btn_cancel;
      up_prev     <= btn_up;
      down_prev   <= btn_down;
    end
  end

  always_comb begin
    state_n  = state_q;
    cost_n   = cost_q;
    left_n   = left_q;
    press_n  = 1'b0;
    cancel_n = 1'b0;
    err_n    = err_q;
    timer_n  = timer_q;

    if (state_q == S_IDLE) begin
      if (card_in) state_n = S_CARD;
    end else if (!card_in) begin
      state_n = S_IDLE;
      cost_n  = '0;
      err_n   = 1'b0;
    end else begin
      unique case (state_q)
        S_CARD: begin
          if (ev_up) begin
            state_n = S_INPUT;
            cost_n  = STEP;
          end
        end
        S_INPUT: begin
          if (ev_cancel) begin
            state_n  = S_CARD;
            cost_n   = '0;
            err_n    = 1'b0;
            cancel_n = 1'b1;
          end else if (ev_ok) begin
            if (cost_q <= left_q) begin
              left_n  = left_q - cost_q;
              press_n = 1'b1;
              state_n = S_DONE;
              timer_n = '0;
            end else begin
              err_n = 1'b1;
            end
          end else if (ev_up) begin
            cost_n = cost_up;
          end else if (ev_down) begin
            cost_n = cost_down;
            err_n  = 1'b0;
          end
        end
        S_DONE: begin
          if (ev_cancel) begin
            state_n  = S_CARD;
            cost_n   = '0;
            cancel_n = 1'b1;
          end else if (timer_q == timer_last) begin
            state_n = S_CARD;
            cost_n  = '0;
          end else begin
            timer_n = timer_q + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign state       = state_q;
  assign cost        = cost_q;
  assign left        = left_q;
  assign press       = press_q;
  assign cancel_flag = cancel_q;
  assign err         = err_q;

endmodule

// File: tb/tb_pay_ctrl.sv
// tb_pay_ctrl: directed self-checking bench for pay_ctrl with hand-computed
// expected values.
module tb_pay_ctrl;

  logic       clk_N = 1'b0;
  logic       rst = 1'b1;
  logic       card_in = 1'b0;
  logic       btn_ok = 1'b0;
  logic       btn_cancel = 1'b0;
  logic       btn_up = 1'b0;
  logic       btn_down = 1'b0;
  logic [1:0] state;
  logic [7:0] cost;
  logic [7:0] left;
  logic       press;
  logic       cancel_flag;
  logic       err;

  int unsigned total = 0;
  int unsigned bad = 0;

  localparam logic [3:0] B_OK = 4'b1000, B_CAN = 4'b0100, B_UP = 4'b0010, B_DN = 4'b0001;

  pay_ctrl #(.INIT_LEFT(8'd132), .STEP(8'd1), .DONE_CYCLES(16'd100)) dut (
    .clk_N(clk_N), .rst(rst), .card_in(card_in),
    .btn_ok(btn_ok), .btn_cancel(btn_cancel), .btn_up(btn_up), .btn_down(btn_down),
    .state(state), .cost(cost), .left(left), .press(press),
    .cancel_flag(cancel_flag), .err(err)
  );

  always #5 clk_N = ~clk_N;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_N);
    #1;
  endtask

  // Drive a set of button levels, then let one edge register them.
  task automatic hit(input logic [3:0] m);
    {btn_ok, btn_cancel, btn_up, btn_down} = m;
    tick();
  endtask

  task automatic release_all();
    {btn_ok, btn_cancel, btn_up, btn_down} = 4'b0000;
    tick();
  endtask

  task automatic tap(input logic [3:0] m, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      hit(m);
      release_all();
    end
  endtask

  task automatic check_all(input string tag, input logic [1:0] s, input logic [7:0] c,
                           input logic [7:0] l, input logic p, input logic cf, input logic e);
    check({tag, ".state"}, 32'(state), 32'(s));
    check({tag, ".cost"}, 32'(cost), 32'(c));
    check({tag, ".left"}, 32'(left), 32'(l));
    check({tag, ".press"}, 32'(press), 32'(p));
    check({tag, ".cancel"}, 32'(cancel_flag), 32'(cf));
    check({tag, ".err"}, 32'(err), 32'(e));
  endtask

  initial begin
    // Reset held for two cycles.
    rst = 1'b1;
    tick();
    tick();
    check_all("reset", 2'b00, 8'd0, 8'd132, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    // Basic purchase of 3.
    card_in = 1'b1;
    tick();
    check("card_state", 32'(state), 32'd1);
    tap(B_UP, 3);
    check("input_state", 32'(state), 32'd2);
    check("cost3", 32'(cost), 32'd3);
    hit(B_OK);
    check_all("buy3", 2'b11, 8'd3, 8'd129, 1'b1, 1'b0, 1'b0);
    release_all();
    check("press_1cyc", 32'(press), 32'd0);
    for (int unsigned i = 0; i < 98; i++) tick();
    check("done_hold", 32'(state), 32'd3);
    check("done_cost_held", 32'(cost), 32'd3);
    tick();
    check("done_exit_state", 32'(state), 32'd1);
    check("done_exit_cost", 32'(cost), 32'd0);

    // Held button counts once; saturation at 255.
    btn_up = 1'b1;
    for (int unsigned i = 0; i < 50; i++) tick();
    release_all();
    check("hold_once", 32'(cost), 32'd1);
    tap(B_UP, 260);
    check("saturate", 32'(cost), 32'd255);
    hit(B_CAN);
    check_all("cancel_sat", 2'b01, 8'd0, 8'd129, 1'b0, 1'b1, 1'b0);
    release_all();
    check("cancel_1cyc", 32'(cancel_flag), 32'd0);

    // Down at zero stays zero.
    tap(B_UP, 1);
    tap(B_DN, 2);
    check("down_floor", 32'(cost), 32'd0);
    check("down_floor_state", 32'(state), 32'd2);

    // Spend 126 to leave 3, then cancel during DONE.
    tap(B_UP, 126);
    hit(B_OK);
    check("buy126_left", 32'(left), 32'd3);
    release_all();
    hit(B_CAN);
    check_all("cancel_done", 2'b01, 8'd0, 8'd3, 1'b0, 1'b1, 1'b0);
    release_all();

    // Insufficient balance, then recover.
    tap(B_UP, 5);
    hit(B_OK);
    check_all("insufficient", 2'b10, 8'd5, 8'd3, 1'b0, 1'b0, 1'b1);
    release_all();
    tap(B_DN, 2);
    check("err_cleared", 32'(err), 32'd0);
    check("cost_after_down", 32'(cost), 32'd3);
    hit(B_OK);
    check_all("buy_exact", 2'b11, 8'd3, 8'd0, 1'b1, 1'b0, 1'b0);
    release_all();
    hit(B_CAN);
    release_all();

    // Cancel during INPUT with cost 7.
    tap(B_UP, 7);
    check("cost7", 32'(cost), 32'd7);
    hit(B_CAN);
    check_all("cancel_input", 2'b01, 8'd0, 8'd0, 1'b0, 1'b1, 1'b0);
    release_all();

    // ok with cost 0 enters DONE without debit; async reset mid-DONE.
    tap(B_UP, 1);
    tap(B_DN, 1);
    hit(B_OK);
    check_all("ok_zero", 2'b11, 8'd0, 8'd0, 1'b1, 1'b0, 1'b0);
    release_all();
    #2;
    rst = 1'b1;
    #1;
    check_all("async_rst", 2'b00, 8'd0, 8'd132, 1'b0, 1'b0, 1'b0);
    tick();
    rst = 1'b0;

    // Same-cycle cancel+ok in INPUT: cancel wins, no debit.
    tick();
    check("rst_card", 32'(state), 32'd1);
    tap(B_UP, 2);
    hit(B_CAN | B_OK);
    check_all("cancel_vs_ok", 2'b01, 8'd0, 8'd132, 1'b0, 1'b1, 1'b0);
    release_all();

    // Up+down together: up wins.
    tap(B_UP, 2);
    hit(B_UP | B_DN);
    check("up_vs_down", 32'(cost), 32'd3);
    release_all();

    // Card removal during INPUT.
    tap(B_UP, 1);
    card_in = 1'b0;
    tick();
    check_all("card_out", 2'b00, 8'd0, 8'd132, 1'b0, 1'b0, 1'b0);
    tick();
    check("idle_stays", 32'(state), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
